// File: rtl/vjtag_multichan_if.sv
// Multi-channel virtual JTAG data interface: NCH DW-bit channels behind one DR shift path,
// with address/auto-increment, readback and status DRs. Define VJTAG_PARITY_EN to add a WRITE parity bit.
module vjtag_multichan_if #(
  parameter int DW  = 8,
  parameter int NCH = 4,
  parameter int IRW = 3,
  localparam int AW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              tck,
  input  logic              aclr,
  input  logic              tdi,
  input  logic [IRW-1:0]    ir_in,
  input  logic              v_cdr,
  input  logic              v_sdr,
  input  logic              udr,
  output logic              tdo,
  output logic [NCH*DW-1:0] data_out,
  output logic [NCH-1:0]    wr_strobe,
  input  logic [NCH*DW-1:0] data_in,
  output logic [NCH-1:0]    rd_strobe,
  output logic [AW-1:0]     cur_addr
);

`ifdef VJTAG_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int SW0 = (DW + P > AW + 1) ? DW + P : AW + 1;
  localparam int SW  = (SW0 > 8) ? SW0 : 8;

  typedef enum logic [2:0] {
    INS_BYPASS = 3'd0,
    INS_WRITE  = 3'd1,
    INS_READ   = 3'd2,
    INS_ADDR   = 3'd3,
    INS_STATUS = 3'd4
  } ins_e;

  ins_e            ins;
  int              dr_len;
  logic [SW-1:0]   sr;
  logic [SW-1:0]   sr_shift;
  logic [SW-1:0]   cap_val;
  logic            bypass;
  logic [AW-1:0]   addr;
  logic [AW-1:0]   addr_inc;
  logic [NCH-1:0]  addr_oh;
  logic            addr_ok;
  logic            autoinc;
  logic [5:0]      wr_count;
  logic            parity_err;
  logic            parity_ok;
  logic [DW-1:0]   ch_q [NCH];
  logic [DW-1:0]   din  [NCH];

  for (genvar k = 0; k < NCH; k++) begin : g_pack
    assign data_out[k*DW +: DW] = ch_q[k];
    assign din[k]               = data_in[k*DW +: DW];
  end

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    ins = INS_BYPASS;
    case (ir_in)
      IRW'(1): ins = INS_WRITE;
      IRW'(2): ins = INS_READ;
      IRW'(3): ins = INS_ADDR;
      IRW'(4): ins = INS_STATUS;
      default: ins = INS_BYPASS;
    endcase
  end

  always_comb begin
    dr_len = 1;
    case (ins)
      INS_WRITE:  dr_len = DW + P;
      INS_READ:   dr_len = DW;
      INS_ADDR:   dr_len = AW + 1;
      INS_STATUS: dr_len = 8;
      default:    dr_len = 1;
    endcase
  end

  // Shift enters tdi at the top of the active DR so short DRs work inside the wide register.
  always_comb begin
    sr_shift = {tdi, sr[SW-1:1]};
    for (int i = 0; i < SW; i++) begin
      if (i == dr_len - 1) sr_shift[i] = tdi;
    end
  end

  always_comb begin
    cap_val = '0;
    case (ins)
      INS_WRITE: begin
        cap_val[DW-1:0] = ch_q[addr];
`ifdef VJTAG_PARITY_EN
        cap_val[DW] = ^ch_q[addr];
`endif
      end
      INS_READ:   cap_val[DW-1:0] = din[addr];
      INS_ADDR:   cap_val[AW:0]   = {autoinc, addr};
      INS_STATUS: cap_val[7:0]    = {parity_err, autoinc, wr_count};
      default:    cap_val = '0;
    endcase
  end

  assign addr_inc = (32'(addr) == NCH - 1) ? '0 : addr + 1'b1;
  assign addr_oh  = NCH'(1) << addr;
  assign addr_ok  = 32'(sr[AW-1:0]) < NCH;
`ifdef VJTAG_PARITY_EN
  assign parity_ok = ~(^sr[DW:0]);
`else
  assign parity_ok = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge tck) begin
    if (!aclr) begin
      sr         <= '0;
      bypass     <= 1'b0;
      addr       <= '0;
      autoinc    <= 1'b0;
      wr_count   <= '0;
      parity_err <= 1'b0;
      wr_strobe  <= '0;
      rd_strobe  <= '0;
      // NOTE: the channel registers are visible outputs that must read 0 after reset, so this array is reset.
      for (int k = 0; k < NCH; k++) ch_q[k] <= '0;
    end else begin
      wr_strobe <= '0;
      rd_strobe <= '0;
      if (v_cdr) begin
        if (ins == INS_BYPASS) bypass <= 1'b0;
        else                   sr     <= cap_val;
        if (ins == INS_READ) rd_strobe <= addr_oh;
      end else if (v_sdr) begin
        if (ins == INS_BYPASS) bypass <= tdi;
        else                   sr     <= sr_shift;
      end

      if (udr) begin
        case (ins)
          INS_WRITE: begin
            if (parity_ok) begin
              ch_q[addr] <= sr[DW-1:0];
              wr_strobe  <= addr_oh;
              wr_count   <= wr_count + 6'd1;
              if (autoinc) addr <= addr_inc;
            end
`ifdef VJTAG_PARITY_EN
            else parity_err <= 1'b1;
`endif
          end
          INS_READ: if (autoinc) addr <= addr_inc;
          INS_ADDR: begin
            autoinc <= sr[AW];
            if (addr_ok) addr <= sr[AW-1:0];
          end
          INS_STATUS: begin
`ifdef VJTAG_PARITY_EN
            if (sr[7]) parity_err <= 1'b0;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign tdo      = (ins == INS_BYPASS) ? bypass : sr[0];
  assign cur_addr = addr;

endmodule

// File: tb/tb_vjtag_multichan_if.sv
// Self-checking bench for vjtag_multichan_if: transaction-level model of the DR scans,
// a per-cycle compare process, and literal expectations for the directed scenarios.
module tb_vjtag_multichan_if;
  localparam int DW  = 8;
  localparam int NCH = 4;
  localparam int IRW = 3;
  localparam int AW  = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef VJTAG_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int C_BYPASS = 0, C_WRITE = 1, C_READ = 2, C_ADDR = 3, C_STATUS = 4;

  logic              tck = 1'b0;
  logic              aclr = 1'b0;
  logic              tdi = 1'b0;
  logic [IRW-1:0]    ir_in = '0;
  logic              v_cdr = 1'b0;
  logic              v_sdr = 1'b0;
  logic              udr = 1'b0;
  logic              tdo;
  logic [NCH*DW-1:0] data_out;
  logic [NCH-1:0]    wr_strobe;
  logic [NCH*DW-1:0] data_in = '0;
  logic [NCH-1:0]    rd_strobe;
  logic [AW-1:0]     cur_addr;

  vjtag_multichan_if #(.DW(DW), .NCH(NCH), .IRW(IRW)) dut (
    .tck(tck), .aclr(aclr), .tdi(tdi), .ir_in(ir_in),
    .v_cdr(v_cdr), .v_sdr(v_sdr), .udr(udr), .tdo(tdo),
    .data_out(data_out), .wr_strobe(wr_strobe), .data_in(data_in),
    .rd_strobe(rd_strobe), .cur_addr(cur_addr)
  );

  always #5 tck = ~tck;

  // Reference model state (transaction level)
  logic [DW-1:0]  m_ch [NCH];
  int             m_addr;
  bit             m_autoinc;
  int             m_wr_count;
  bit             m_perr;
  bit             m_sr0;
  bit             m_bypass;
  logic [NCH-1:0] exp_wr;
  logic [NCH-1:0] exp_rd;
  bit             exp_valid = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0]    got_cap;
  logic [63:0]    got_out;
  logic [NCH-1:0] last_wr;
  logic [NCH-1:0] last_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_bypass(input int code);
    return !(code >= C_WRITE && code <= C_STATUS);
  endfunction

  function automatic int dr_len(input int code);
    case (code)
      C_WRITE:  return DW + P;
      C_READ:   return DW;
      C_ADDR:   return AW + 1;
      C_STATUS: return 8;
      default:  return 3;
    endcase
  endfunction

  function automatic logic [63:0] capture_value(input int code);
    logic [63:0] c;
    c = '0;
    case (code)
      C_WRITE: begin
        c[DW-1:0] = m_ch[m_addr];
        if (P == 1) c[DW] = ^m_ch[m_addr];
      end
      C_READ:   c[DW-1:0] = data_in[m_addr*DW +: DW];
      C_ADDR:   c = 64'({m_autoinc, AW'(m_addr)});
      C_STATUS: c = 64'({m_perr, m_autoinc, 6'(m_wr_count)});
      default:  c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [NCH*DW-1:0] model_data_out();
    logic [NCH*DW-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*DW +: DW] = m_ch[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) m_ch[k] = '0;
    m_addr = 0; m_autoinc = 0; m_wr_count = 0; m_perr = 0;
    m_sr0 = 0; m_bypass = 0;
    exp_wr = '0; exp_rd = '0;
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
    exp_wr = '0;
    exp_rd = '0;
  endtask

  task automatic apply_update(input int code, input logic [63:0] bits);
    case (code)
      C_WRITE: begin
        if (P == 1 && (^bits[DW:0])) m_perr = 1;
        else begin
          m_ch[m_addr] = bits[DW-1:0];
          exp_wr       = NCH'(1) << m_addr;
          m_wr_count   = (m_wr_count + 1) % 64;
          if (m_autoinc) m_addr = (m_addr + 1) % NCH;
        end
      end
      C_READ: if (m_autoinc) m_addr = (m_addr + 1) % NCH;
      C_ADDR: begin
        m_autoinc = bits[AW];
        if (int'(bits[AW-1:0]) < NCH) m_addr = int'(bits[AW-1:0]);
      end
      C_STATUS: if (bits[7]) m_perr = 0;
      default: ;
    endcase
  endtask

  // One DR transaction: capture, shift len bits, optional update under upd_code; abort_at>=0 pulls reset on that shift.
  task automatic scan(input int code, input logic [63:0] bits, input bit upd, input int upd_code, input int abort_at);
    int          len;
    bit          byp;
    logic [63:0] cap, stream, mask;
    byp  = is_bypass(code);
    len  = dr_len(code);
    cap  = capture_value(code);
    mask = (64'd1 << len) - 64'd1;
    stream = cap | ((bits & mask) << len);
    got_cap = '0;
    got_out = '0;
    last_wr = '0;
    ir_in = IRW'(code);
    v_cdr = 1'b1;
    tick();
    v_cdr = 1'b0;
    if (byp) m_bypass = 0; else m_sr0 = cap[0];
    if (code == C_READ) exp_rd = NCH'(1) << m_addr;
    last_rd    = rd_strobe;
    got_cap[0] = tdo;
    for (int k = 0; k < len; k++) begin
      v_sdr = 1'b1;
      tdi   = bits[k];
      if (k == abort_at) aclr = 1'b0;
      tick();
      if (k == abort_at) begin
        model_reset();
        aclr  = 1'b1;
        v_sdr = 1'b0;
        tick();
        return;
      end
      if (byp) m_bypass = bits[k]; else m_sr0 = stream[k+1];
      got_out[k] = tdo;
      if (k + 1 < len) got_cap[k+1] = tdo;
    end
    v_sdr = 1'b0;
    if (upd) begin
      ir_in = IRW'(upd_code);
      udr   = 1'b1;
      tick();
      udr = 1'b0;
      apply_update(upd_code, bits);
      last_wr = wr_strobe;
    end
    tick();
  endtask

  always @(negedge tck) begin
    if (exp_valid) begin
      check("data_out", data_out, model_data_out());
      check("cur_addr", cur_addr, m_addr);
      check("wr_strobe", wr_strobe, exp_wr);
      check("rd_strobe", rd_strobe, exp_rd);
      check("tdo", tdo, is_bypass(int'(ir_in)) ? m_bypass : m_sr0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] bits;
    int          code, upd_code, abort_at;
    bit          upd;

    aclr = 1'b0;
    tick();
    model_reset();
    exp_valid = 1'b1;
    tick();
    aclr = 1'b1;

    scan(C_STATUS, 64'h0, 1'b0, C_STATUS, -1);
    check("status_after_reset", got_cap[7:0], 8'h00);
    check("addr_after_reset", cur_addr, 0);
    check("data_after_reset", data_out, 0);

    scan(C_ADDR, 64'b110, 1'b1, C_ADDR, -1);
    check("addr_set_2", cur_addr, 2);
    scan(C_WRITE, 64'hA5, 1'b1, C_WRITE, -1);
    check("write_ch2", data_out[23:16], 8'hA5);
    check("write_strobe_ch2", last_wr, 4'b0100);
    check("autoinc_to_3", cur_addr, 3);

    data_in = '0;
    data_in[31:24] = 8'h3C;
    scan(C_READ, 64'h0, 1'b1, C_READ, -1);
    check("read_ch3_stream", got_cap[7:0], 8'h3C);
    check("read_strobe_ch3", last_rd, 4'b1000);
    check("read_wrap_addr", cur_addr, 0);

    scan(C_ADDR, 64'b101, 1'b1, C_ADDR, -1);
    check("addr_field_1", cur_addr, 1);
    scan(C_STATUS, 64'h0, 1'b0, C_STATUS, -1);
    check("status_autoinc", got_cap[6], 1'b1);
    check("status_wr_count", got_cap[5:0], 6'd1);

    scan(C_BYPASS, 64'b101, 1'b0, C_BYPASS, -1);
    check("bypass_capture_zero", got_cap[0], 1'b0);
    check("bypass_delay", got_out[2:0], 3'b101);
    scan(6, 64'b011, 1'b1, 6, -1);
    check("unknown_ir_bypass", got_out[2:0], 3'b011);

    scan(C_WRITE, 64'h77, 1'b1, C_READ, -1);
    check("ir_change_no_write", data_out[15:8], 8'h00);
    check("ir_change_read_inc", cur_addr, 2);

`ifdef VJTAG_PARITY_EN
    scan(C_WRITE, 64'h10F, 1'b1, C_WRITE, -1);
    check("parity_reject_data", data_out[23:16], 8'hA5);
    check("parity_reject_strobe", last_wr, 4'b0000);
    check("parity_reject_addr", cur_addr, 2);
    scan(C_STATUS, 64'h0, 1'b0, C_STATUS, -1);
    check("parity_err_set", got_cap[7], 1'b1);
    scan(C_STATUS, 64'h80, 1'b1, C_STATUS, -1);
    scan(C_STATUS, 64'h0, 1'b0, C_STATUS, -1);
    check("parity_err_cleared", got_cap[7], 1'b0);
    scan(C_WRITE, 64'h0, 1'b0, C_WRITE, -1);
    check("parity_readback", got_cap[8:0], 9'h0A5);
`endif

    scan(C_WRITE, 64'h5A, 1'b1, C_WRITE, 4);
    check("abort_data_zero", data_out, 0);
    check("abort_addr_zero", cur_addr, 0);
    check("abort_no_strobe", wr_strobe, 0);
    scan(C_WRITE, 64'h0, 1'b0, C_WRITE, -1);
    check("abort_readback_zero", got_cap[DW-1:0], 0);

    for (int n = 0; n < 300; n++) begin
      code = int'($urandom_range(0, 7));
      bits = {$urandom, $urandom};
      if (P == 1 && code == C_WRITE && $urandom_range(0, 3) != 0) bits[DW] = ^bits[DW-1:0];
      for (int k = 0; k < NCH; k++) data_in[k*DW +: DW] = DW'($urandom);
      upd      = ($urandom_range(0, 3) != 0);
      upd_code = code;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 4))
          0: upd_code = C_BYPASS;
          1: upd_code = C_READ;
          2: upd_code = 5;
          3: upd_code = 6;
          default: upd_code = 7;
        endcase
      end
      abort_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, dr_len(code) - 1)) : -1;
      scan(code, bits, upd, upd_code, abort_at);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
